// File: rtl/stopwatch_core.sv
// stopwatch_core: mixed-radix BCD stopwatch engine. A prescaler divides the clock
// into tenths ticks; the time register counts tenths, seconds and MIN_DIGITS minute
// digits. Supports lap capture, pause with preserved prescaler phase and a one-cycle
// overflow pulse on wrap.
// Optional feature: define STOPWATCH_COUNTDOWN_EN to add load_p/load_value,
// count_down and the done pulse.
//
// state | meaning
// IDLE  | cleared, not counting
// RUN   | counting, live time displayed
// PAUSE | stopped, prescaler phase held for resume
// LAP   | counting, captured lap time displayed
module stopwatch_core #(
  parameter int  DIV        = 10000000,
  parameter int  MIN_DIGITS = 2,
  localparam int W          = 4 * (3 + MIN_DIGITS)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_stop_p,
  input  logic         lap_p,
  input  logic         clear_p,
`ifdef STOPWATCH_COUNTDOWN_EN
  input  logic         count_down,
  input  logic         load_p,
  input  logic [W-1:0] load_value,
  output logic         done,
`endif
  output logic [W-1:0] digits,
  output logic         running,
  output logic         lap_active,
  output logic         overflow
);

  localparam int ND = 3 + MIN_DIGITS;
  localparam int PW = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

  // sec-tens digit is radix 6, every other digit radix 10
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 2) ? 4'd5 : 4'd9;
  endfunction

  // returns {carry_out, incremented time}
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] t);
    logic [W-1:0] r;
    logic         c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (t[4*i +: 4] >= digit_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

`ifdef STOPWATCH_COUNTDOWN_EN
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] t);
    logic [W-1:0] r;
    logic         b;
    r = t;
    b = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (b) begin
        if (t[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = t[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // out-of-range load digits are saturated so no digit exceeds its radix
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] t);
    logic [W-1:0] r;
    r = t;
    for (int i = 0; i < ND; i++) begin
      if (t[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
    end
    return r;
  endfunction
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  time_q, time_d;
  logic [W-1:0]  lap_q, lap_d;
  logic [W-1:0]  digits_q, digits_d;
  logic          running_q, running_d;
  logic          lap_active_q, lap_active_d;
  logic          overflow_q, overflow_d;
  logic          active;
  logic          tick;
  logic          start_ok;
  logic [W:0]    inc;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic          done_q, done_d;
  logic [W-1:0]  dec;
`endif

  // next state: prescaler and time update first, then button events by priority
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    time_d     = time_q;
    lap_d      = lap_q;
    overflow_d = 1'b0;
    active     = (state_q == S_RUN) || (state_q == S_LAP);
    tick       = active && (presc_q == PW'(DIV - 1));
    inc        = bcd_inc(time_q);
`ifdef STOPWATCH_COUNTDOWN_EN
    done_d     = 1'b0;
    dec        = bcd_dec(time_q);
    start_ok   = !(count_down && (time_q == '0));
`else
    start_ok   = 1'b1;
`endif

    if (active) presc_d = tick ? '0 : presc_q + 1'b1;

    if (tick) begin
`ifdef STOPWATCH_COUNTDOWN_EN
      if (count_down) begin
        time_d = dec;
        done_d = (dec == '0);
      end else begin
        time_d     = inc[W-1:0];
        overflow_d = inc[W];
      end
`else
      time_d     = inc[W-1:0];
      overflow_d = inc[W];
`endif
    end

    if (clear_p) begin
      state_d    = S_IDLE;
      presc_d    = '0;
      time_d     = '0;
      lap_d      = '0;
      overflow_d = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      done_d     = 1'b0;
`endif
    end else begin
      if (start_stop_p) begin
        case (state_q)
          S_IDLE, S_PAUSE: if (start_ok) state_d = S_RUN;
          S_RUN, S_LAP:    state_d = S_PAUSE;
          default:         state_d = S_IDLE;
        endcase
      end else if (lap_p) begin
        if (state_q == S_RUN) begin
          state_d = S_LAP;
          lap_d   = time_q;
        end else if (state_q == S_LAP) begin
          state_d = S_RUN;
        end
      end
`ifdef STOPWATCH_COUNTDOWN_EN
      if (load_p && !active) begin
        time_d  = bcd_clamp(load_value);
        presc_d = '0;
      end
      if (done_d) state_d = S_PAUSE;
`endif
    end

    running_d    = (state_d == S_RUN) || (state_d == S_LAP);
    lap_active_d = (state_d == S_LAP);
    digits_d     = (state_q == S_LAP) ? lap_q : time_q;
  end

  // single register stage for FSM, counters and all outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      time_q       <= '0;
      lap_q        <= '0;
      digits_q     <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      done_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      time_q       <= time_d;
      lap_q        <= lap_d;
      digits_q     <= digits_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
`ifdef STOPWATCH_COUNTDOWN_EN
      done_q       <= done_d;
`endif
    end
  end

  assign digits     = digits_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;
`ifdef STOPWATCH_COUNTDOWN_EN
  assign done       = done_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scenarios plus randomized button traffic, every cycle
// compared against a reference model that keeps time as a plain tenths count.
module tb_stopwatch_core;

  localparam int DIV        = 3;
  localparam int MIN_DIGITS = 1;
  localparam int W          = 4 * (3 + MIN_DIGITS);
  localparam int MAXN       = 600 * (10 ** MIN_DIGITS);

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start_stop_p = 1'b0;
  logic         lap_p = 1'b0;
  logic         clear_p = 1'b0;
  logic         count_down = 1'b0;
  logic         load_p = 1'b0;
  int           load_n = 0;
  logic [W-1:0] digits;
  logic         running;
  logic         lap_active;
  logic         overflow;
`ifdef STOPWATCH_COUNTDOWN_EN
  logic [W-1:0] load_value = '0;
  logic         done;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int           m_n, m_lap, m_cyc;
  bit           m_cnt, m_frz;
  logic [W-1:0] exp_digits;
  bit           exp_run, exp_lap, exp_ovf, exp_done;

  stopwatch_core #(.DIV(DIV), .MIN_DIGITS(MIN_DIGITS)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_stop_p (start_stop_p),
    .lap_p        (lap_p),
    .clear_p      (clear_p),
`ifdef STOPWATCH_COUNTDOWN_EN
    .count_down   (count_down),
    .load_p       (load_p),
    .load_value   (load_value),
    .done         (done),
`endif
    .digits       (digits),
    .running      (running),
    .lap_active   (lap_active),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           m;
    r       = '0;
    r[3:0]  = 4'(n % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[11:8] = 4'((n / 100) % 6);
    m = n / 600;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      r[12 + 4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_lap = 0; m_cyc = 0; m_cnt = 0; m_frz = 0;
    exp_digits = '0; exp_run = 0; exp_lap = 0; exp_ovf = 0; exp_done = 0;
  endtask

  // one clock edge of the stopwatch described as counting/frozen flags and a tenths count
  task automatic model_step(input bit ss, input bit lp, input bit cl);
    bit was_cnt, was_frz, tick, hit;
    int old_n;
    was_cnt = m_cnt; was_frz = m_frz; old_n = m_n;
    exp_digits = to_bcd(was_frz ? m_lap : m_n);
    exp_ovf = 0; exp_done = 0; tick = 0; hit = 0;
    if (was_cnt) begin
      m_cyc++;
      tick = (m_cyc % DIV) == 0;
    end
    if (tick) begin
      if (count_down) begin
        m_n = (m_n == 0) ? MAXN - 1 : m_n - 1;
        hit = (m_n == 0);
      end else if (m_n == MAXN - 1) begin
        m_n = 0;
        exp_ovf = 1;
      end else begin
        m_n++;
      end
    end
    if (cl) begin
      m_cnt = 0; m_frz = 0; m_n = 0; m_cyc = 0; m_lap = 0; exp_ovf = 0;
    end else begin
      if (ss) begin
        if (was_cnt) begin
          m_cnt = 0; m_frz = 0;
        end else if (!(count_down && old_n == 0)) begin
          m_cnt = 1; m_frz = 0;
        end
      end else if (lp && was_cnt) begin
        if (!was_frz) m_lap = old_n;
        m_frz = !was_frz;
      end
      if (load_p && !was_cnt) begin
        m_n = load_n; m_cyc = 0;
      end
      if (hit) begin
        m_cnt = 0; m_frz = 0; exp_done = 1;
      end
    end
    exp_run = m_cnt;
    exp_lap = m_frz;
  endtask

  task automatic cycle(input bit ss, input bit lp, input bit cl);
    start_stop_p = ss; lap_p = lp; clear_p = cl;
    @(posedge clock);
    model_step(ss, lp, cl);
    #1;
    check("digits", 32'(digits), 32'(exp_digits));
    check("running", 32'(running), 32'(exp_run));
    check("lap_active", 32'(lap_active), 32'(exp_lap));
    check("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef STOPWATCH_COUNTDOWN_EN
    check("done", 32'(done), 32'(exp_done));
`endif
    start_stop_p = 0; lap_p = 0; clear_p = 0; load_p = 0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("arst_digits", 32'(digits), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_lap", 32'(lap_active), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] live;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_lap", 32'(lap_active), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    #1 reset = 1'b0;

    // one second of counting, including the one-cycle display lag
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int k = 0; k < 30; k++) cycle(0, 0, 0);
    check("t1_lag", 32'(digits), 32'h0009);
    cycle(0, 0, 0);
    check("t1_digits", 32'(digits), 32'h0010);
    check("t1_running", 32'(running), 32'd1);

    // pause with prescaler at DIV-1, resume completes the partial tick
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int k = 0; k < 20; k++) cycle(0, 0, 0);
    check("pause_hold", 32'(digits), 32'h0001);
    check("pause_run", 32'(running), 32'd0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("resume_t1", 32'(digits), 32'h0001);
    cycle(0, 0, 0);
    check("resume_t2", 32'(digits), 32'h0002);

    // minute carry and full wrap with overflow pulse
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    for (int k = 0; k < 2500 && m_n != 600; k++) cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("carry_min", 32'(digits), 32'h1000);
    for (int k = 0; k < 20000; k++) begin
      cycle(0, 0, 0);
      if (exp_ovf) break;
    end
    check("wrap_ovf", 32'(overflow), 32'd1);
    check("wrap_pre", 32'(digits), 32'h9599);
    cycle(0, 0, 0);
    check("wrap_zero", 32'(digits), 32'h0000);
    check("wrap_ovf_clr", 32'(overflow), 32'd0);

    // lap freeze and release
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    for (int k = 0; k < 300 && m_n != 35; k++) cycle(0, 0, 0);
    cycle(0, 1, 0);
    for (int k = 0; k < 100; k++) begin
      cycle(0, 0, 0);
      check("lap_frozen", 32'(digits), 32'h0035);
    end
    check("lap_flag", 32'(lap_active), 32'd1);
    cycle(0, 1, 0);
    live = to_bcd(m_n);
    check("lap_off", 32'(lap_active), 32'd0);
    cycle(0, 0, 0);
    check("lap_release", 32'(digits), 32'(live));

    // clear beats start_stop and lap in the same cycle
    cycle(1, 1, 1);
    check("prio_running", 32'(running), 32'd0);
    check("prio_lap", 32'(lap_active), 32'd0);
    cycle(0, 0, 0);
    check("prio_digits", 32'(digits), 32'd0);

    // asynchronous reset in the middle of a count
    cycle(1, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 0, 0);
    async_reset();

    // randomized button traffic
    for (int k = 0; k < 3000; k++) begin
`ifdef STOPWATCH_COUNTDOWN_EN
      if (k % 400 == 0) count_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        load_n = $urandom_range(0, MAXN - 1);
        load_value = to_bcd(load_n);
        load_p = 1'b1;
      end
`endif
      cycle(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 199) == 0));
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    // count down from 0.2 s to zero
    cycle(0, 0, 1);
    count_down = 1'b1;
    load_n = 2;
    load_value = to_bcd(2);
    load_p = 1'b1;
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0);
    check("cd_first", 32'(digits), 32'h0001);
    for (int k = 0; k < 20 && !exp_done; k++) cycle(0, 0, 0);
    check("cd_done", 32'(done), 32'd1);
    check("cd_running", 32'(running), 32'd0);
    cycle(0, 0, 0);
    check("cd_zero", 32'(digits), 32'd0);
    cycle(1, 0, 0);
    check("cd_start_ignored", 32'(running), 32'd0);
    count_down = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1);
  end

endmodule
